// File: rtl/byte_joining_ctrl.sv
// Lane-word to byte-stream sequencer: captures a 1/2/4-lane word and emits its
// bytes lane 0 first under ready/valid handshakes on both sides.
module byte_joining_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk1Mhz,
  input  logic             reset,
  input  logic [1:0]       lanes_mode,
  input  logic [WIDTH-1:0] Lane_0,
  input  logic [WIDTH-1:0] Lane_1,
  input  logic [WIDTH-1:0] Lane_2,
  input  logic [WIDTH-1:0] Lane_3,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] byte_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       ctr_3,
  output logic             word_done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q [4];
  logic [WIDTH-1:0] hold_d [4];
  logic [1:0]       last_q, last_d;
  logic [1:0]       ctr_q, ctr_d;
  logic [1:0]       nxtIdx;
  logic [WIDTH-1:0] byteOut_q, byteOut_d;
  logic             outValid_q, outValid_d;
  logic             wordDone_q, wordDone_d;
  logic             cfgErr_q, cfgErr_d;
  logic [CNT_W-1:0] wordCount_q, wordCount_d;

  logic capture;
  logic xfer;
  logic lastXfer;

  assign capture  = in_valid & in_ready;
  assign xfer     = outValid_q & out_ready;
  assign lastXfer = xfer & (ctr_q == last_q);
  assign nxtIdx   = ctr_q + 2'd1;

  always_ff @(posedge clk1Mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = SEND;
      SEND: if (lastXfer && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accepting a new word in SEND only when the last byte leaves this cycle
  // gives back-to-back words without a bubble and without mixing bytes.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      SEND:    in_ready = out_ready & (ctr_q == last_q);
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    last_d      = last_q;
    ctr_d       = ctr_q;
    byteOut_d   = byteOut_q;
    outValid_d  = outValid_q;
    cfgErr_d    = cfgErr_q;
    wordDone_d  = lastXfer;
    wordCount_d = wordCount_q;
    if (lastXfer) begin
      wordCount_d = wordCount_q + CNT_W'(1);
    end
    if (capture) begin
      hold_d[0]  = Lane_0;
      hold_d[1]  = Lane_1;
      hold_d[2]  = Lane_2;
      hold_d[3]  = Lane_3;
      // last_q holds N-1; the reserved encoding runs as four lanes
      unique case (lanes_mode)
        2'b00:   last_d = 2'd0;
        2'b01:   last_d = 2'd1;
        default: last_d = 2'd3;
      endcase
      cfgErr_d   = cfgErr_q | (lanes_mode == 2'b11);
      byteOut_d  = Lane_0;
      ctr_d      = 2'd0;
      outValid_d = 1'b1;
    end else if (lastXfer) begin
      ctr_d      = 2'd0;
      outValid_d = 1'b0;
    end else if (xfer) begin
      ctr_d     = nxtIdx;
      byteOut_d = hold_q[nxtIdx];
    end
  end

  always_ff @(posedge clk1Mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= '0;
      end
      last_q      <= '0;
      ctr_q       <= '0;
      byteOut_q   <= '0;
      outValid_q  <= 1'b0;
      wordDone_q  <= 1'b0;
      cfgErr_q    <= 1'b0;
      wordCount_q <= '0;
    end else begin
      hold_q      <= hold_d;
      last_q      <= last_d;
      ctr_q       <= ctr_d;
      byteOut_q   <= byteOut_d;
      outValid_q  <= outValid_d;
      wordDone_q  <= wordDone_d;
      cfgErr_q    <= cfgErr_d;
      wordCount_q <= wordCount_d;
    end
  end

  assign byte_out   = byteOut_q;
  assign out_valid  = outValid_q;
  assign ctr_3      = ctr_q;
  assign word_done  = wordDone_q;
  assign cfg_err    = cfgErr_q;
  assign word_count = wordCount_q;

endmodule

// File: tb/tb_byte_joining_ctrl.sv
// Directed bench for byte_joining_ctrl: hand-computed byte streams, handshakes,
// mode handling, reset and counter wrap (counter narrowed to 4 bits).
module tb_byte_joining_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk1Mhz = 1'b0;
  logic             reset;
  logic [1:0]       lanesMode;
  logic [WIDTH-1:0] lane0, lane1, lane2, lane3;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] byteOut;
  logic             outValid;
  logic             outReady;
  logic [1:0]       ctr3;
  logic             wordDone;
  logic             cfgErr;
  logic [CNT_W-1:0] wordCount;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk1Mhz = ~clk1Mhz;

  byte_joining_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk1Mhz    (clk1Mhz),
    .reset      (reset),
    .lanes_mode (lanesMode),
    .Lane_0     (lane0),
    .Lane_1     (lane1),
    .Lane_2     (lane2),
    .Lane_3     (lane3),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .byte_out   (byteOut),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .ctr_3      (ctr3),
    .word_done  (wordDone),
    .cfg_err    (cfgErr),
    .word_count (wordCount)
  );

  task automatic tick();
    @(posedge clk1Mhz);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] m,
                               input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] l3);
    inValid   = v;
    lanesMode = m;
    lane0     = l0;
    lane1     = l1;
    lane2     = l2;
    lane3     = l3;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkByte(input string tag, input logic [7:0] b, input logic [1:0] c);
    checkOutput({tag, ".byte"}, 32'(byteOut), 32'(b));
    checkOutput({tag, ".ctr"}, 32'(ctr3), 32'(c));
    checkOutput({tag, ".valid"}, 32'(outValid), 32'd1);
  endtask

  task automatic checkIdle(input string tag, input int wc);
    checkOutput({tag, ".valid"}, 32'(outValid), 32'd0);
    checkOutput({tag, ".ctr"}, 32'(ctr3), 32'd0);
    checkOutput({tag, ".done"}, 32'(wordDone), 32'd1);
    checkOutput({tag, ".count"}, 32'(wordCount), 32'(wc));
  endtask

  initial begin
    reset    = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    checkOutput("rst.byte", 32'(byteOut), 32'd0);
    checkOutput("rst.valid", 32'(outValid), 32'd0);
    checkOutput("rst.ctr", 32'(ctr3), 32'd0);
    checkOutput("rst.done", 32'(wordDone), 32'd0);
    checkOutput("rst.cfg", 32'(cfgErr), 32'd0);
    checkOutput("rst.count", 32'(wordCount), 32'd0);
    checkOutput("rst.inReady", 32'(inReady), 32'd1);
    tick();
    reset = 1'b0;

    // x4 back-to-back words
    $display("[TB] x4 back-to-back");
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h01, 8'h02, 8'h04);
    tick();
    applyStimulus(1'b1, 2'b10, 8'h01, 8'h02, 8'h03, 8'h05);
    checkByte("b2b.c1", 8'h00, 2'd0);
    checkOutput("b2b.c1.inReady", 32'(inReady), 32'd0);
    tick(); checkByte("b2b.c2", 8'h01, 2'd1);
    tick(); checkByte("b2b.c3", 8'h02, 2'd2);
    tick(); checkByte("b2b.c4", 8'h04, 2'd3);
    checkOutput("b2b.c4.inReady", 32'(inReady), 32'd1);
    tick();
    applyStimulus(1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("b2b.c5", 8'h01, 2'd0);
    checkOutput("b2b.c5.done", 32'(wordDone), 32'd1);
    checkOutput("b2b.c5.count", 32'(wordCount), 32'd1);
    tick(); checkByte("b2b.c6", 8'h02, 2'd1);
    checkOutput("b2b.c6.done", 32'(wordDone), 32'd0);
    tick(); checkByte("b2b.c7", 8'h03, 2'd2);
    tick(); checkByte("b2b.c8", 8'h05, 2'd3);
    tick(); checkIdle("b2b.c9", 2);

    // x1 then x2
    $display("[TB] x1 and x2");
    applyStimulus(1'b1, 2'b00, 8'hAA, 8'h11, 8'h22, 8'h33);
    tick();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("x1.b0", 8'hAA, 2'd0);
    checkOutput("x1.inReady", 32'(inReady), 32'd1);
    tick(); checkIdle("x1.end", 3);
    applyStimulus(1'b1, 2'b01, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    tick();
    applyStimulus(1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("x2.b0", 8'hAA, 2'd0);
    tick(); checkByte("x2.b1", 8'hBB, 2'd1);
    tick(); checkIdle("x2.end", 4);

    // Backpressure at lane 2
    $display("[TB] backpressure");
    applyStimulus(1'b1, 2'b10, 8'h10, 8'h20, 8'h30, 8'h40);
    tick();
    applyStimulus(1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("bp.b0", 8'h10, 2'd0);
    tick(); checkByte("bp.b1", 8'h20, 2'd1);
    tick();
    outReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkByte("bp.hold", 8'h30, 2'd2);
      checkOutput("bp.hold.inReady", 32'(inReady), 32'd0);
      if (i < 2) tick();
    end
    outReady = 1'b1;
    tick(); checkByte("bp.b3", 8'h40, 2'd3);
    tick(); checkIdle("bp.end", 5);

    // Mode change mid-word
    $display("[TB] mid-word mode change");
    applyStimulus(1'b1, 2'b10, 8'h51, 8'h52, 8'h53, 8'h54);
    tick();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("mm.b0", 8'h51, 2'd0);
    checkOutput("mm.inReady", 32'(inReady), 32'd0);
    tick(); checkByte("mm.b1", 8'h52, 2'd1);
    tick(); checkByte("mm.b2", 8'h53, 2'd2);
    tick(); checkByte("mm.b3", 8'h54, 2'd3);
    tick(); checkIdle("mm.end", 6);
    applyStimulus(1'b1, 2'b00, 8'h61, 8'h62, 8'h63, 8'h64);
    tick();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("mm.next", 8'h61, 2'd0);
    tick(); checkIdle("mm.next.end", 7);

    // Reserved mode
    $display("[TB] reserved mode");
    checkOutput("cfg.before", 32'(cfgErr), 32'd0);
    applyStimulus(1'b1, 2'b11, 8'h71, 8'h72, 8'h73, 8'h74);
    tick();
    applyStimulus(1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("rsv.b0", 8'h71, 2'd0);
    checkOutput("rsv.cfg", 32'(cfgErr), 32'd1);
    tick(); checkByte("rsv.b1", 8'h72, 2'd1);
    tick(); checkByte("rsv.b2", 8'h73, 2'd2);
    tick(); checkByte("rsv.b3", 8'h74, 2'd3);
    tick(); checkIdle("rsv.end", 8);
    applyStimulus(1'b1, 2'b01, 8'h81, 8'h82, 8'h83, 8'h84);
    tick();
    applyStimulus(1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("rsv.legal.b0", 8'h81, 2'd0);
    tick(); checkByte("rsv.legal.b1", 8'h82, 2'd1);
    tick(); checkIdle("rsv.legal.end", 9);
    checkOutput("rsv.sticky", 32'(cfgErr), 32'd1);

    // Asynchronous reset mid-word
    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 2'b10, 8'h91, 8'h92, 8'h93, 8'h94);
    tick();
    applyStimulus(1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick(); checkByte("ar.pre", 8'h93, 2'd2);
    reset = 1'b1;
    #1;
    checkOutput("ar.byte", 32'(byteOut), 32'd0);
    checkOutput("ar.valid", 32'(outValid), 32'd0);
    checkOutput("ar.ctr", 32'(ctr3), 32'd0);
    checkOutput("ar.cfg", 32'(cfgErr), 32'd0);
    checkOutput("ar.count", 32'(wordCount), 32'd0);
    checkOutput("ar.inReady", 32'(inReady), 32'd1);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 2'b01, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    tick();
    applyStimulus(1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
    checkByte("ar.post.b0", 8'hA1, 2'd0);
    checkOutput("ar.post.count", 32'(wordCount), 32'd0);
    tick(); checkByte("ar.post.b1", 8'hA2, 2'd1);
    tick(); checkIdle("ar.post.end", 1);

    // 16 back-to-back x1 words wrap the 4-bit counter
    $display("[TB] counter wrap");
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'b00, 8'(i + 8'hC0), 8'hEE, 8'hEE, 8'hEE);
      tick();
      checkByte("wrap.b", 8'(i + 8'hC0), 2'd0);
    end
    checkOutput("wrap.count15", 32'(wordCount), 32'd15);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick(); checkIdle("wrap.end", 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
